// File: rtl/apb_arb_master.sv
// Round-robin APB master: NUM_REQ requesters share one APB bus, one transfer at a time.
// Optional ACCESS-phase timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arb_master #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic                             PREADY,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PSLVERR
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_gnt;
    logic [NUM_REQ-1:0]    r_req_ready;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic                  w_any;
    logic [PW-1:0]         w_gnt;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [NUM_REQ-1:0]    w_cur_oh;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]         r_wait;
`endif

    // Search upward from the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        w_any = 1'b0;
        w_gnt = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = PW'(idx);
            end
        end
    end

    assign w_gnt_oh = NUM_REQ'(1) << w_gnt;
    assign w_cur_oh = NUM_REQ'(1) << r_gnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            r_wait      <= '0;
`endif
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_gnt;
                        r_pwrite    <= req_write[w_gnt];
                        r_paddr     <= req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                        r_pwdata    <= req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                        r_psel      <= 1'b1;
                        r_req_ready <= w_gnt_oh;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_ptr     <= (r_gnt == PW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    r_wait    <= '0;
`endif
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_cur_oh;
                        r_rsp_err   <= PSLVERR;
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                        r_state     <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (r_wait == CW'(TIMEOUT - 1)) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_cur_oh;
                        r_rsp_err   <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule
